// File: rtl/lag_tolerant_checker_pkg.sv
// Shared state encoding and defaults for the lag-tolerant golden/observed checker.
package lag_tolerant_checker_pkg;

  typedef enum logic [1:0] {
    CHK_SYNC = 2'b00,
    CHK_WAIT = 2'b01,
    CHK_ERR  = 2'b10
  } chk_state_e;

  localparam int DEF_LAG_MAX = 3;
  localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/lag_tolerant_checker_chk_channel.sv
// One compared signal: lag-window FSM, registered mismatch pulse, saturating
// error counter and sticky flag.
module lag_tolerant_checker_chk_channel
  import lag_tolerant_checker_pkg::*;
#(
  parameter int LAG_MAX = DEF_LAG_MAX,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enable,
  input  logic             clear_counts,
  input  logic             exp,
  input  logic             obs,
  output logic             detect,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output chk_state_e       state
);

  localparam int LAG_W = (LAG_MAX < 1) ? 1 : $clog2(LAG_MAX + 1);

  chk_state_e       next_state;
  logic [LAG_W-1:0] lag, next_lag;
  logic             target, next_target;
  logic             exp_q;
  logic             exp_edge;

  assign exp_edge = (exp != exp_q);

  always_comb begin
    next_state  = state;
    next_lag    = lag;
    next_target = target;
    detect      = 1'b0;
    if (!enable) begin
      next_state = CHK_SYNC;
      next_lag   = '0;
    end else begin
      unique case (state)
        CHK_SYNC: begin
          if (obs != exp) begin
            if (exp_edge && (LAG_MAX > 0)) begin
              next_state  = CHK_WAIT;
              next_target = exp;
              next_lag    = LAG_W'(1);
            end else begin
              next_state = CHK_ERR;
              detect     = 1'b1;
            end
          end
        end
        CHK_WAIT: begin
          if (obs == target) begin
            next_state = CHK_SYNC;
            next_lag   = '0;
          end else if (exp != target) begin
            // exp moved again before obs caught up: that transition was dropped
            detect      = 1'b1;
            next_target = exp;
            next_lag    = LAG_W'(1);
          end else if (lag == LAG_W'(LAG_MAX)) begin
            next_state = CHK_ERR;
            next_lag   = '0;
            detect     = 1'b1;
          end else begin
            next_lag = lag + LAG_W'(1);
          end
        end
        CHK_ERR: begin
          if (obs == exp) next_state = CHK_SYNC;
        end
        default: begin
          next_state = CHK_SYNC;
          next_lag   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state  <= CHK_SYNC;
      lag    <= '0;
      target <= 1'b0;
      exp_q  <= 1'b0;
    end else begin
      state  <= next_state;
      lag    <= next_lag;
      target <= next_target;
      exp_q  <= exp;
    end
  end

  // A detection coinciding with clear_counts survives the clear.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else begin
      mismatch <= detect;
      if (clear_counts) begin
        err_sticky <= detect;
        err_count  <= detect ? CNT_W'(1) : '0;
      end else if (detect) begin
        err_sticky <= 1'b1;
        if (err_count != '1) err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/lag_tolerant_checker.sv
// N_CH-channel golden vs. observed comparator with per-channel lag tolerance,
// first-error capture (lowest channel wins ties) and a global error flag.
module lag_tolerant_checker
  import lag_tolerant_checker_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int LAG_MAX = DEF_LAG_MAX,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  enable,
  input  logic                  clear_counts,
  input  logic [N_CH-1:0]       exp,
  input  logic [N_CH-1:0]       obs,
  output logic [N_CH-1:0]       mismatch,
  output logic [N_CH-1:0]       err_sticky,
  output logic [N_CH*CNT_W-1:0] err_count,
  output logic                  first_err_valid,
  output logic [CH_W-1:0]       first_err_ch,
  output logic                  any_err,
  output logic [2*N_CH-1:0]     dbg_state
);

  logic [N_CH-1:0] detect;
  logic            any_detect;
  logic [CH_W-1:0] first_idx;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    chk_state_e ch_state;

    lag_tolerant_checker_chk_channel #(
      .LAG_MAX(LAG_MAX),
      .CNT_W  (CNT_W)
    ) u_chan (
      .clk         (clk),
      .reset_L     (reset_L),
      .enable      (enable),
      .clear_counts(clear_counts),
      .exp         (exp[g]),
      .obs         (obs[g]),
      .detect      (detect[g]),
      .mismatch    (mismatch[g]),
      .err_sticky  (err_sticky[g]),
      .err_count   (err_count[g*CNT_W +: CNT_W]),
      .state       (ch_state)
    );

    assign dbg_state[2*g +: 2] = ch_state;
  end

  assign any_detect = |detect;
  assign any_err    = |err_sticky;

  // Scan high to low so the lowest erroring index is left in first_idx.
  always_comb begin
    first_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (detect[i]) first_idx = CH_W'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      first_err_valid <= 1'b0;
      first_err_ch    <= '0;
    end else if (clear_counts) begin
      first_err_valid <= any_detect;
      first_err_ch    <= any_detect ? first_idx : '0;
    end else if (!first_err_valid && any_detect) begin
      first_err_valid <= 1'b1;
      first_err_ch    <= first_idx;
    end
  end

endmodule

// File: tb/tb_lag_tolerant_checker.sv
// Directed bench for lag_tolerant_checker (N_CH=2, LAG_MAX=3, CNT_W=4).
module tb_lag_tolerant_checker;

  localparam int N_CH  = 2;
  localparam int CNT_W = 4;
  localparam int CH_W  = 1;

  logic                  clk;
  logic                  reset_L;
  logic                  enable;
  logic                  clear_counts;
  logic [N_CH-1:0]       exp;
  logic [N_CH-1:0]       obs;
  logic [N_CH-1:0]       mismatch;
  logic [N_CH-1:0]       err_sticky;
  logic [N_CH*CNT_W-1:0] err_count;
  logic                  first_err_valid;
  logic [CH_W-1:0]       first_err_ch;
  logic                  any_err;
  logic [2*N_CH-1:0]     dbg_state;

  logic [N_CH-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  lag_tolerant_checker #(
    .N_CH   (N_CH),
    .LAG_MAX(3),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .reset_L        (reset_L),
    .enable         (enable),
    .clear_counts   (clear_counts),
    .exp            (exp),
    .obs            (obs),
    .mismatch       (mismatch),
    .err_sticky     (err_sticky),
    .err_count      (err_count),
    .first_err_valid(first_err_valid),
    .first_err_ch   (first_err_ch),
    .any_err        (any_err),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Drive one cycle of inputs on the falling edge; mm is the mismatch vector
  // expected just after the following rising edge.
  task automatic cyc(input logic [1:0] e, input logic [1:0] o, input logic [1:0] mm);
    logic [N_CH-1:0] want;
    @(negedge clk);
    exp = e;
    obs = o;
    exp_q.push_back(mm);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    check("mismatch", 32'(mismatch), 32'(want));
    clear_counts = 1'b0;
  endtask

  task automatic check_counts(input string tag, input logic [3:0] c0, input logic [3:0] c1);
    check({tag, "_count0"}, 32'(err_count[3:0]), 32'(c0));
    check({tag, "_count1"}, 32'(err_count[7:4]), 32'(c1));
  endtask

  initial begin
    reset_L      = 1'b0;
    enable       = 1'b1;
    clear_counts = 1'b0;
    exp          = '0;
    obs          = '0;
    #12;
    check("reset_mismatch", 32'(mismatch), 0);
    check("reset_sticky", 32'(err_sticky), 0);
    check("reset_count", 32'(err_count), 0);
    check("reset_first_valid", 32'(first_err_valid), 0);
    check("reset_any_err", 32'(any_err), 0);
    check("reset_state", 32'(dbg_state), 0);
    @(negedge clk);
    reset_L = 1'b1;
    for (int i = 0; i < 3; i++) cyc(2'b00, 2'b00, 2'b00);

    // obs[0] follows the exp edge two cycles late: tolerated
    cyc(2'b01, 2'b00, 2'b00);
    check("lag_wait_state", 32'(dbg_state[1:0]), 32'h1);
    cyc(2'b01, 2'b00, 2'b00);
    cyc(2'b01, 2'b01, 2'b00);
    cyc(2'b01, 2'b01, 2'b00);
    check("lag_ok_state", 32'(dbg_state[1:0]), 32'h0);
    check_counts("lag_ok", 4'd0, 4'd0);
    check("lag_ok_first_valid", 32'(first_err_valid), 0);

    // obs[0] never follows: single pulse after the lag window expires
    cyc(2'b00, 2'b00, 2'b00);
    cyc(2'b01, 2'b00, 2'b00);
    cyc(2'b01, 2'b00, 2'b00);
    cyc(2'b01, 2'b00, 2'b00);
    cyc(2'b01, 2'b00, 2'b01);
    cyc(2'b01, 2'b00, 2'b00);
    cyc(2'b01, 2'b00, 2'b00);
    check_counts("timeout", 4'd1, 4'd0);
    check("timeout_sticky", 32'(err_sticky), 32'h1);
    check("timeout_first_valid", 32'(first_err_valid), 1);
    check("timeout_first_ch", 32'(first_err_ch), 0);
    check("timeout_any_err", 32'(any_err), 1);
    check("timeout_err_state", 32'(dbg_state[1:0]), 32'h2);
    cyc(2'b01, 2'b01, 2'b00);
    cyc(2'b01, 2'b01, 2'b00);

    // spurious obs[1] toggle with exp stable
    cyc(2'b01, 2'b11, 2'b10);
    cyc(2'b01, 2'b11, 2'b00);
    cyc(2'b01, 2'b01, 2'b00);
    cyc(2'b01, 2'b01, 2'b00);
    check_counts("spurious", 4'd1, 4'd1);
    check("spurious_first_ch", 32'(first_err_ch), 0);
    check("spurious_sticky", 32'(err_sticky), 32'h3);

    // clear, then both channels fail together; then saturate channel 1
    clear_counts = 1'b1;
    cyc(2'b01, 2'b01, 2'b00);
    check_counts("cleared", 4'd0, 4'd0);
    check("cleared_sticky", 32'(err_sticky), 0);
    check("cleared_first_valid", 32'(first_err_valid), 0);
    check("cleared_any_err", 32'(any_err), 0);
    cyc(2'b01, 2'b10, 2'b11);
    check_counts("both", 4'd1, 4'd1);
    check("both_first_valid", 32'(first_err_valid), 1);
    check("both_first_ch", 32'(first_err_ch), 0);
    cyc(2'b01, 2'b01, 2'b00);
    for (int i = 0; i < 20; i++) begin
      cyc(2'b01, 2'b11, 2'b10);
      cyc(2'b01, 2'b01, 2'b00);
    end
    check_counts("saturate", 4'd1, 4'd15);

    // error coinciding with clear_counts wins
    clear_counts = 1'b1;
    cyc(2'b01, 2'b11, 2'b10);
    check_counts("clear_race", 4'd0, 4'd1);
    check("clear_race_sticky", 32'(err_sticky), 32'h2);
    check("clear_race_first_valid", 32'(first_err_valid), 1);
    check("clear_race_first_ch", 32'(first_err_ch), 1);
    cyc(2'b01, 2'b01, 2'b00);

    // dropped transition: exp[0] pulses high for one cycle, obs[0] stays low
    cyc(2'b00, 2'b00, 2'b00);
    cyc(2'b01, 2'b00, 2'b00);
    cyc(2'b00, 2'b00, 2'b01);
    cyc(2'b00, 2'b00, 2'b00);
    cyc(2'b00, 2'b00, 2'b00);
    check("dropped_state", 32'(dbg_state[1:0]), 32'h0);
    check_counts("dropped", 4'd1, 4'd1);

    // asynchronous reset in the middle of a WAIT
    cyc(2'b01, 2'b00, 2'b00);
    check("pre_reset_wait", 32'(dbg_state[1:0]), 32'h1);
    @(negedge clk);
    #2;
    reset_L = 1'b0;
    exp     = 2'b00;
    obs     = 2'b00;
    enable  = 1'b0;
    #1;
    check("async_mismatch", 32'(mismatch), 0);
    check("async_sticky", 32'(err_sticky), 0);
    check("async_count", 32'(err_count), 0);
    check("async_first_valid", 32'(first_err_valid), 0);
    check("async_any_err", 32'(any_err), 0);
    check("async_state", 32'(dbg_state), 0);
    @(negedge clk);
    reset_L = 1'b1;

    // disabled: no pulses despite edges and obs!=exp; enabling reports spurious
    cyc(2'b01, 2'b00, 2'b00);
    cyc(2'b01, 2'b00, 2'b00);
    cyc(2'b01, 2'b10, 2'b00);
    check_counts("disabled", 4'd0, 4'd0);
    check("disabled_state", 32'(dbg_state), 0);
    enable = 1'b1;
    cyc(2'b01, 2'b10, 2'b11);
    check_counts("enable", 4'd1, 4'd1);
    check("enable_first_ch", 32'(first_err_ch), 0);
    cyc(2'b01, 2'b01, 2'b00);
    cyc(2'b01, 2'b01, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
